boot_mem: RTL and testbench
===========================

Name: boot_mem

Overview:
- Memory responder on the far end of the CPU memory bus: 2^ADDR_WIDTH x DATA_WIDTH single-port RAM with synchronous read.
- Matches the CPU's two-phase access: address issued in one phase, data consumed in the next.
- Adds a streaming boot-loader port that fills program memory from LOAD_BASE while the CPU is held in reset.
- Releases the CPU through cpu_rst_n when loading completes; sits between the top level, the CPU and an external program source.

Parameters:
ADDR_WIDTH, 6, address width; memory depth 2^ADDR_WIDTH words
DATA_WIDTH, 16, word width
LOAD_BASE, 8, first address written by the loader (CPU first-instruction address)
BOOT_LOAD, 1, 1 = load phase after reset; 0 = skip loading and release the CPU directly

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_WIDTH  CPU access address
cpu_wdata  input  DATA_WIDTH  CPU write data
cpu_rdata  output  DATA_WIDTH  registered read data, drives CPU mem_in
cpu_rst_n  output  1  registered active-low reset to the CPU
ld_valid  input  1  loader word valid
ld_data  input  DATA_WIDTH  loader word
ld_last  input  1  marks the final loader word; sampled with ld_valid
ld_ready  output  1  loader may transfer
ld_count  output  ADDR_WIDTH+1  words accepted in the current load
ld_err  output  1  sticky flag: memory top reached without ld_last

Behaviour:
- Reset is clk/rst_n, asynchronous, active-low. Reset values:
  - state = LOAD if BOOT_LOAD=1, else RELEASE
  - cpu_rst_n=0, cpu_rdata=0, ld_count=0, ld_err=0
  - write pointer = LOAD_BASE
- Memory array contents are not reset.
- ld_ready is decoded from state: 1 only in LOAD, so it is high from reset when BOOT_LOAD=1.
- FSM:
  - LOAD:
    - Beat accepted when ld_valid & ld_ready at posedge. On an accepted beat: mem[ptr] <= ld_data, ptr <= ptr+1, ld_count <= ld_count+1.
    - ld_valid low: nothing is written and ptr holds. Gaps of any length are allowed.
    - Accepted beat with ld_last=1 -> RELEASE.
    - Accepted beat at ptr = 2^ADDR_WIDTH-1 with ld_last=0: write it, set ld_err=1, -> RELEASE. ptr never wraps.
    - Accepted beat at the top address with ld_last=1 -> RELEASE, ld_err stays 0.
  - RELEASE: exactly one cycle, cpu_rst_n still 0 -> RUN.
  - RUN:
    - cpu_rst_n <= 1, registered; it rises on the edge that enters RUN.
    - Stays in RUN until rst_n. ld_valid is ignored and ld_ready=0. A reload requires reset.
- CPU port:
  - Active only in RUN; ignored in LOAD/RELEASE, where cpu_rdata holds 0.
  - Read (cpu_we=0): cpu_rdata <= mem[cpu_addr] at the posedge. One-cycle latency: address presented in cycle n, data valid in cycle n+1.
  - Write (cpu_we=1): mem[cpu_addr] <= cpu_wdata and cpu_rdata <= cpu_wdata (write-through).
- Holds:
  - ld_count and ld_err hold their values in RELEASE/RUN until reset.
  - Width of ld_count covers the full depth; maximum value is 2^ADDR_WIDTH - LOAD_BASE.
- Reset mid-load: immediate return to the reset state with ptr=LOAD_BASE and ld_count=0. Words already written remain in the array. cpu_rst_n stays 0.

Test Plan:
- Reset, load 0x7800, 0x8800, 0xF000 (ld_last on the third), ld_valid continuous -> mem[8..10] hold those words, ld_count=3, ld_err=0. cpu_rst_n=0 through RELEASE and rises on the second edge after the last accept.
- Same three words with ld_valid low for 2 cycles between beats -> identical memory contents and ld_count=3; no writes during the gaps.
- RUN read: cpu_addr=9, cpu_we=0 at edge n -> cpu_rdata=0x8800 after edge n. Then addr=10 -> 0xF000 at edge n+1.
- RUN write-through: cpu_we=1, addr=3, data=0x1234 -> cpu_rdata=0x1234 next cycle. Subsequent read of addr 3 -> 0x1234.
- Overflow: stream 56 words (addresses 8..63) with ld_last never set -> automatic RELEASE→RUN, ld_err=1, ld_count=56, ld_ready=0 afterwards; extra ld_valid beats are ignored.
- Reset asserted after 2 of 3 beats, then reloaded with 0xAAAA (ld_last) -> ld_count=1, mem[8]=0xAAAA, cpu_rst_n low throughout the reset; BOOT_LOAD=0 build: cpu_rst_n rises on the first edge after reset release, ld_ready=0 always.

Source files
------------

// File: rtl/boot_mem.sv
// Single-port boot RAM for the CPU memory bus. After reset it optionally streams a
// program in from LOAD_BASE, then releases the CPU and serves its two-phase accesses.
module boot_mem #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_BASE  = 8,
  parameter bit BOOT_LOAD  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rst_n,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic                  ld_err
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(LOAD_BASE);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  accept;
  logic                  at_top;
  logic                  cpu_active;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT_LOAD ? LOAD : RELEASE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      LOAD:    if (accept && (ld_last || at_top)) state_next = RELEASE;
      RELEASE: state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  // State-decoded outputs and strobes
  always_comb begin
    ld_ready   = (state == LOAD);
    cpu_active = (state == RUN);
    accept     = ld_valid && (state == LOAD);
    at_top     = (ptr == TOP_ADDR);
  end

  // Loader beats and CPU writes never coincide, so one write port serves both.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_addr;
    mem_wdata = cpu_wdata;
    if (accept) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = ld_data;
    end else if (cpu_active && cpu_we) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset branch; contents survive rst_n and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      ptr       <= BASE_ADDR;
      ld_count  <= '0;
      ld_err    <= 1'b0;
      cpu_rst_n <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      // cpu_rst_n rises on the very edge that enters RUN.
      cpu_rst_n <= (state_next == RUN);
      if (accept) begin
        ld_count <= ld_count + 1'b1;
        // The pointer parks at the top address instead of wrapping.
        if (!at_top) ptr <= ptr + 1'b1;
        if (at_top && !ld_last) ld_err <= 1'b1;
      end
      if (cpu_active) begin
        cpu_rdata <= cpu_we ? cpu_wdata : mem[cpu_addr];
      end
    end
  end

endmodule

// File: tb/tb_boot_mem.sv
// Directed bench for boot_mem: loading, gaps, CPU read/write-through, overflow,
// reset mid-load, top-address last beat, and a BOOT_LOAD=0 instance.
module tb_boot_mem;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;

  logic [DW-1:0] cpu_rdata, nb_cpu_rdata;
  logic          cpu_rst_n, nb_cpu_rst_n;
  logic          ld_ready, nb_ld_ready;
  logic [AW:0]   ld_count, nb_ld_count;
  logic          ld_err, nb_ld_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  boot_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_BASE(8), .BOOT_LOAD(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rst_n(cpu_rst_n), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_count(ld_count), .ld_err(ld_err)
  );

  boot_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_BASE(8), .BOOT_LOAD(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(nb_cpu_rdata), .cpu_rst_n(nb_cpu_rst_n), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(nb_ld_ready), .ld_count(nb_ld_count), .ld_err(nb_ld_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    cpu_we   = 1'b0;
    cpu_addr = a;
    step();
    check(tag, 32'(cpu_rdata), 32'(exp));
  endtask

  // Assert reset between edges, check the async values, release after one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst ld_count", 32'(ld_count), 32'd0);
    check("rst nb cpu_rst_n", 32'(nb_cpu_rst_n), 32'd0);
    step();
    check("rst held cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    #23;

    // Reset state
    check("reset cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("reset ld_count", 32'(ld_count), 32'd0);
    check("reset ld_err", 32'(ld_err), 32'd0);
    check("reset ld_ready", 32'(ld_ready), 32'd1);
    check("reset nb ld_ready", 32'(nb_ld_ready), 32'd0);
    step();
    rst_n = 1'b1;

    // Continuous three-word load; BOOT_LOAD=0 instance releases on the first edge
    beat(16'h7800, 1'b0);
    check("nb cpu_rst_n first edge", 32'(nb_cpu_rst_n), 32'd1);
    check("nb ld_ready", 32'(nb_ld_ready), 32'd0);
    check("load1 count", 32'(ld_count), 32'd1);
    beat(16'h8800, 1'b0);
    check("load2 count", 32'(ld_count), 32'd2);
    beat(16'hF000, 1'b1);
    check("load3 count", 32'(ld_count), 32'd3);
    check("release ld_ready", 32'(ld_ready), 32'd0);
    check("release cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("release cpu_rdata", 32'(cpu_rdata), 32'd0);
    step();
    check("run cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("run ld_err", 32'(ld_err), 32'd0);

    // Reads with one-cycle latency, then write-through
    cpu_read(6'd8, 16'h7800, "rd mem8");
    cpu_read(6'd9, 16'h8800, "rd mem9");
    cpu_read(6'd10, 16'hF000, "rd mem10");
    cpu_we = 1'b1; cpu_addr = 6'd3; cpu_wdata = 16'h1234;
    step();
    check("write-through", 32'(cpu_rdata), 32'h1234);
    cpu_we = 1'b1; cpu_addr = 6'd11; cpu_wdata = 16'h5555;
    step();
    cpu_we = 1'b1; cpu_addr = 6'd12; cpu_wdata = 16'h6666;
    step();
    cpu_read(6'd9, 16'h8800, "rd mem9 again");
    cpu_read(6'd3, 16'h1234, "rd mem3");
    beat(16'hDEAD, 1'b1);
    check("run ignores loader", 32'(ld_count), 32'd3);
    check("run nb ld_ready", 32'(nb_ld_ready), 32'd0);

    // Gapped load: garbage on ld_data while ld_valid is low must not be written
    do_reset();
    for (int i = 0; i < 3; i++) begin
      beat((i == 0) ? 16'h7800 : (i == 1) ? 16'h8800 : 16'hF000, i == 2);
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          ld_data = 16'hBAD0 + 16'(g);
          step();
          check("gap count hold", 32'(ld_count), 32'(i + 1));
        end
      end
    end
    check("gap final count", 32'(ld_count), 32'd3);
    step();
    check("gap cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    cpu_read(6'd8, 16'h7800, "gap mem8");
    cpu_read(6'd9, 16'h8800, "gap mem9");
    cpu_read(6'd10, 16'hF000, "gap mem10");
    cpu_read(6'd11, 16'h5555, "gap mem11 untouched");
    cpu_read(6'd12, 16'h6666, "gap mem12 untouched");

    // Reset mid-load after two beats, then a single-word reload
    do_reset();
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    check("midload count", 32'(ld_count), 32'd2);
    rst_n = 1'b0;
    #2;
    check("midload rst count", 32'(ld_count), 32'd0);
    check("midload rst cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("midload rst ld_ready", 32'(ld_ready), 32'd1);
    step();
    rst_n = 1'b1;
    beat(16'hAAAA, 1'b1);
    check("reload count", 32'(ld_count), 32'd1);
    step();
    cpu_read(6'd8, 16'hAAAA, "reload mem8");
    cpu_read(6'd9, 16'h2222, "reload mem9 kept");

    // Overflow: 56 words with no ld_last
    do_reset();
    for (int i = 0; i < 56; i++) begin
      if (i == 55) check("ovf ready before top", 32'(ld_ready), 32'd1);
      beat(16'h1000 + 16'(i), 1'b0);
    end
    check("ovf ld_err", 32'(ld_err), 32'd1);
    check("ovf count", 32'(ld_count), 32'd56);
    check("ovf ld_ready", 32'(ld_ready), 32'd0);
    check("ovf cpu_rst_n release", 32'(cpu_rst_n), 32'd0);
    beat(16'hEEEE, 1'b0);
    check("ovf cpu_rst_n run", 32'(cpu_rst_n), 32'd1);
    beat(16'hEEEE, 1'b1);
    check("ovf extra ignored", 32'(ld_count), 32'd56);
    check("ovf err sticky", 32'(ld_err), 32'd1);
    cpu_read(6'd8, 16'h1000, "ovf mem8");
    cpu_read(6'd63, 16'h1037, "ovf mem63");

    // ld_last exactly at the top address: no error
    do_reset();
    for (int i = 0; i < 56; i++) beat(16'h2000 + 16'(i), i == 55);
    check("top-last err", 32'(ld_err), 32'd0);
    check("top-last count", 32'(ld_count), 32'd56);
    step();
    check("top-last cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    cpu_read(6'd63, 16'h2037, "top-last mem63");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
